// File: rtl/ysyx_store_queue_if.sv
// Store queue ports: LSU push side, AXI-like write bus side,
// load conflict probe and fence handshake.
interface ysyx_store_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic [XLEN-1:0] in_addr;
   logic [XLEN-1:0] in_wdata;
   logic [7:0]      in_wstrb;
   logic            out_in_ready;

   logic [XLEN-1:0] out_lsu_awaddr;
   logic            out_lsu_awvalid;
   logic [XLEN-1:0] out_lsu_wdata;
   logic [7:0]      out_lsu_wstrb;
   logic            out_lsu_wvalid;
   logic            lsu_wready;

   logic [XLEN-1:0] ld_addr;
   logic            out_ld_conflict;
   logic            fence_req;
   logic            out_fence_done;
   logic [CW-1:0]   out_count;

   modport master (
      output in_valid, in_addr, in_wdata, in_wstrb,
      output lsu_wready, ld_addr, fence_req,
      input  out_in_ready, out_lsu_awaddr, out_lsu_awvalid,
      input  out_lsu_wdata, out_lsu_wstrb, out_lsu_wvalid,
      input  out_ld_conflict, out_fence_done, out_count
   );

   modport slave (
      input  in_valid, in_addr, in_wdata, in_wstrb,
      input  lsu_wready, ld_addr, fence_req,
      output out_in_ready, out_lsu_awaddr, out_lsu_awvalid,
      output out_lsu_wdata, out_lsu_wstrb, out_lsu_wvalid,
      output out_ld_conflict, out_fence_done, out_count
   );
endinterface

// File: rtl/ysyx_store_queue.sv
// Committed-store FIFO that drains to the bus one write at a time,
// with a one-cycle turnaround gap after every write response.
module ysyx_store_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic              clock,
   input logic              reset,
   ysyx_store_queue_if.slave sq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_GAP
   } state_e;

   state_e          state_q;
   logic            valid_q;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] addr_q [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [7:0]      strb_q [DEPTH];
   logic            push, pop;
   logic            conflict;
   logic [PW-1:0]   slot;
   logic            unused_ld;

   assign sq.out_in_ready = (count_q < CW'(DEPTH)) && !sq.fence_req;
   assign push = sq.in_valid && sq.out_in_ready;
   assign pop  = valid_q && sq.lsu_wready;

   always_comb begin
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Entering BUSY off count_d lets a fresh push reach the bus next cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         unique case (state_q)
            S_IDLE, S_GAP: begin
               if (count_d != '0) begin
                  state_q <= S_BUSY;
                  valid_q <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b0;
               end
            end
            S_BUSY: begin
               if (sq.lsu_wready) begin
                  state_q <= S_GAP;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         addr_q[tail_q] <= sq.in_addr;
         data_q[tail_q] <= sq.in_wdata;
         strb_q[tail_q] <= sq.in_wstrb;
      end
   end

   // Word-granular match over every occupied slot, head included.
   always_comb begin
      conflict = 1'b0;
      slot     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head_q + PW'(k);
         if ((CW'(k) < count_q) &&
             (addr_q[slot][XLEN-1:2] == sq.ld_addr[XLEN-1:2]))
            conflict = 1'b1;
      end
   end

   assign unused_ld = ^sq.ld_addr[1:0];

   assign sq.out_ld_conflict = conflict;
   assign sq.out_lsu_awaddr  = addr_q[head_q];
   assign sq.out_lsu_wdata   = data_q[head_q];
   assign sq.out_lsu_wstrb   = strb_q[head_q];
   assign sq.out_lsu_awvalid = valid_q;
   assign sq.out_lsu_wvalid  = valid_q;
   assign sq.out_count       = count_q;
   assign sq.out_fence_done  = (count_q == '0) && (state_q == S_IDLE);
endmodule

// File: tb/tb_ysyx_store_queue.sv
// Scoreboard bench for ysyx_store_queue: ordered drain, gaps,
// full/wrap, conflict probe, fence and reset recovery.
module tb_ysyx_store_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [7:0]  s;
   } st_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   ysyx_store_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) sq();

   ysyx_store_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset(reset),
      .sq   (sq)
   );

   always #5 clock = ~clock;

   int  checks = 0;
   int  errors = 0;
   st_t sb[$];
   st_t stim[$];
   bit  prev_pop = 1'b0;
   bit  gap_chk = 1'b0;
   bit  exp_busy = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: push on accepted store, pop/compare on bus handshake
   always @(negedge clock) begin
      st_t e;
      bit  pop_now;
      int  n0;
      if (reset) begin
         sb.delete();
         prev_pop = 1'b0;
         gap_chk  = 1'b0;
      end else begin
         n0 = sb.size();
         chk("count", sq.out_count, n0);
         chk("in_ready", sq.out_in_ready,
             (n0 < DEPTH) && !sq.fence_req);
         chk("wvalid_eq", sq.out_lsu_wvalid, sq.out_lsu_awvalid);
         if (gap_chk) chk("after_gap", sq.out_lsu_awvalid, exp_busy);
         gap_chk = prev_pop;
         if (prev_pop) chk("gap", sq.out_lsu_awvalid, 0);
         pop_now = sq.out_lsu_awvalid && sq.lsu_wready;
         if (pop_now) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("pop_addr", sq.out_lsu_awaddr, e.a);
               chk("pop_data", sq.out_lsu_wdata, e.d);
               chk("pop_strb", sq.out_lsu_wstrb, e.s);
            end
         end
         if (sq.in_valid && sq.out_in_ready)
            sb.push_back({sq.in_addr, sq.in_wdata, sq.in_wstrb});
         exp_busy = (sb.size() != 0);
         prev_pop = pop_now;
      end
   end

   task automatic push(input st_t s);
      @(posedge clock); #1;
      sq.in_valid   = 1'b1;
      sq.in_addr    = s.a;
      sq.in_wdata   = s.d;
      sq.in_wstrb   = s.s;
      sq.lsu_wready = 1'b0;
   endtask

   task automatic idle_cyc();
      @(posedge clock); #1;
      sq.in_valid   = 1'b0;
      sq.lsu_wready = 1'b0;
   endtask

   task automatic wait_busy();
      int n = 0;
      while (!sq.out_lsu_awvalid && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk("busy", sq.out_lsu_awvalid, 1);
   endtask

   // Feed stim, answer each write after 'delay' valid cycles
   task automatic run(input int delay, input int bound);
      int n = 0;
      int wait_c = 0;
      bit took = 1'b0;
      while ((stim.size() != 0 || sb.size() != 0 || took) && n < bound) begin
         @(posedge clock); #1;
         sq.in_valid = (stim.size() != 0);
         if (sq.in_valid) begin
            sq.in_addr  = stim[0].a;
            sq.in_wdata = stim[0].d;
            sq.in_wstrb = stim[0].s;
         end
         sq.lsu_wready = sq.out_lsu_awvalid && (wait_c >= delay);
         if (sq.out_lsu_awvalid && !sq.lsu_wready) wait_c++;
         else wait_c = 0;
         #2;
         took = sq.in_valid && sq.out_in_ready;
         if (took) void'(stim.pop_front());
         n++;
      end
      sq.in_valid   = 1'b0;
      sq.lsu_wready = 1'b0;
      chk("drained", stim.size() + sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      st_t a, b, c;
      sq.in_valid   = 1'b0;
      sq.in_addr    = '0;
      sq.in_wdata   = '0;
      sq.in_wstrb   = '0;
      sq.lsu_wready = 1'b0;
      sq.ld_addr    = '0;
      sq.fence_req  = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #2;
      chk("rst_count", sq.out_count, 0);
      chk("rst_awvalid", sq.out_lsu_awvalid, 0);
      chk("rst_ready", sq.out_in_ready, 1);
      chk("rst_fdone", sq.out_fence_done, 1);
      chk("rst_confl", sq.out_ld_conflict, 0);

      // single store, response at cycle 5
      push('{32'h8000_0004, 32'hdead_beef, 8'hf});
      idle_cyc();
      #2;
      chk("s1_awvalid", sq.out_lsu_awvalid, 1);
      chk("s1_awaddr", sq.out_lsu_awaddr, 32'h8000_0004);
      chk("s1_wdata", sq.out_lsu_wdata, 32'hdead_beef);
      chk("s1_wstrb", sq.out_lsu_wstrb, 8'hf);
      repeat (3) idle_cyc();
      chk("s1_hold", sq.out_lsu_awaddr, 32'h8000_0004);
      @(posedge clock); #1 sq.lsu_wready = 1'b1;
      idle_cyc();
      #2;
      chk("s1_count", sq.out_count, 0);
      chk("s1_idle", sq.out_lsu_awvalid, 0);
      repeat (2) idle_cyc();

      // fill to full, then wrap with stores 5 and 6
      for (int i = 1; i <= 4; i++)
         push('{32'h8000_1000 + 32'(i * 4), 32'h1111_0000 + 32'(i),
                (i % 2 == 0) ? 8'h3 : 8'h1});
      push('{32'h8000_1014, 32'h1111_0005, 8'hf});
      #2;
      chk("full_count", sq.out_count, 4);
      chk("full_ready", sq.out_in_ready, 0);
      stim.push_back('{32'h8000_1014, 32'h1111_0005, 8'hf});
      stim.push_back('{32'h8000_1018, 32'h1111_0006, 8'h3});
      run(1, 100);
      repeat (2) idle_cyc();

      // push and pop in the same cycle at count 2
      a = '{32'h8000_2000, 32'haaaa_0001, 8'hf};
      b = '{32'h8000_2004, 32'haaaa_0002, 8'h1};
      c = '{32'h8000_2008, 32'haaaa_0003, 8'h3};
      push(a);
      push(b);
      push(c);
      sq.lsu_wready = 1'b1;
      #2;
      chk("sim_count0", sq.out_count, 2);
      chk("sim_busy", sq.out_lsu_awvalid, 1);
      idle_cyc();
      #2;
      chk("sim_count1", sq.out_count, 2);
      idle_cyc();
      #2;
      chk("sim_head", sq.out_lsu_awaddr, b.a);
      run(0, 50);
      repeat (2) idle_cyc();

      // load conflict probe
      sq.ld_addr = 32'h8000_0100;
      #2;
      chk("cf_empty", sq.out_ld_conflict, 0);
      push('{32'h8000_0100, 32'h0000_0011, 8'hf});
      idle_cyc();
      sq.ld_addr = 32'h8000_0102;
      #1;
      chk("cf_hit", sq.out_ld_conflict, 1);
      sq.ld_addr = 32'h8000_0104;
      #1;
      chk("cf_miss", sq.out_ld_conflict, 0);
      @(posedge clock); #1 sq.lsu_wready = 1'b1;
      idle_cyc();
      sq.ld_addr = 32'h8000_0102;
      #2;
      chk("cf_popped", sq.out_ld_conflict, 0);
      repeat (2) idle_cyc();

      // fence drains three stores and blocks a fourth
      for (int i = 0; i < 3; i++)
         push('{32'h8000_3000 + 32'(i * 4), 32'hf0f0_0000 + 32'(i), 8'hf});
      push('{32'h8000_3100, 32'hbad0_bad0, 8'hf});
      sq.fence_req = 1'b1;
      #2;
      chk("fn_ready", sq.out_in_ready, 0);
      chk("fn_done0", sq.out_fence_done, 0);
      for (int k = 0; k < 3; k++) begin
         wait_busy();
         sq.lsu_wready = 1'b1;
         #1;
         chk("fn_busy_done", sq.out_fence_done, 0);
         @(posedge clock); #1 sq.lsu_wready = 1'b0;
         #2;
         chk("fn_gap_done", sq.out_fence_done, 0);
      end
      @(posedge clock); #3;
      chk("fn_done", sq.out_fence_done, 1);
      chk("fn_count", sq.out_count, 0);
      sq.fence_req = 1'b0;
      sq.in_valid  = 1'b0;
      repeat (2) idle_cyc();

      // reset while busy with three entries
      for (int i = 0; i < 3; i++)
         push('{32'h8000_4000 + 32'(i * 4), 32'h5555_0000 + 32'(i), 8'h1});
      idle_cyc();
      #2;
      chk("rm_count", sq.out_count, 3);
      chk("rm_busy", sq.out_lsu_awvalid, 1);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      #2;
      chk("rm_count0", sq.out_count, 0);
      chk("rm_awvalid", sq.out_lsu_awvalid, 0);
      chk("rm_fdone", sq.out_fence_done, 1);
      repeat (3) idle_cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
